adc_burst_writer: RTL and testbench
===================================

# adc_burst_writer

Collects ADC sample words from a valid/ready stream into a burst buffer and drives the `axi_wr` user interface (enable/status) to store each full burst into a circular DDR window over the FPGA-to-HPS bridge. Sits directly upstream of `axi_wr`. It owns burst assembly, address generation, wrap-around, and the enable/status handshake. Software polls `wr_ptr` to find fresh data.

## Interface
- `ID_WIDTH`, 8: AXI write transaction ID width.
- `ADDR_WIDTH`, 32: byte address width.
- `BUS_WIDTH`, 32: data word width; one sample per word; power of two, 8..1024.
- `BURST_LEN`, 16: words per burst, 1..16.
- `CNT_WIDTH`, 16: width of `buf_words`, `wr_ptr` and `drop_count`.
- `clock` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; IDLE/ERROR → FILL; clears `wr_ptr` and `err`.
- `stop` in 1: level; request return to IDLE.
- `wr_id_in` in ID_WIDTH: ID forwarded to `wr_id`.
- `base_addr` in ADDR_WIDTH: window base; aligned to BURST_LEN*BUS_WIDTH/8 bytes.
- `buf_words` in CNT_WIDTH: window size in words; nonzero multiple of BURST_LEN; static while not IDLE.
- `s_data` in BUS_WIDTH: sample word.
- `s_valid` in 1 / `s_ready` out 1: sample handshake.
- `wr_enable` out 1: to `axi_wr.enable`.
- `wr_id` out ID_WIDTH, `wr_addr` out ADDR_WIDTH, `wr_data` out BURST_LEN*BUS_WIDTH, `wr_burst_len` out 4, `wr_burst_size` out 3, `wr_strb` out BUS_WIDTH/8: to `axi_wr`.
- `wr_status` in 2: from `axi_wr`; 0 ready, 1 wait, 2 ok, 3 error.
- `wr_ptr` out CNT_WIDTH: word offset of the next burst slot.
- `busy` out 1: high whenever state ≠ IDLE.
- `err` out 1: sticky AXI error flag.
- `drop_count` out CNT_WIDTH: dropped samples (only with the macro).

## Operation
- States: IDLE, FILL, WRITE, RELEASE, ERROR.
- IDLE: `s_ready`=0. `start` → FILL, `wr_ptr`=0, `err`=0, fill index=0.
- FILL: `s_ready`=1. Each accepted word is stored at slot index [i*BUS_WIDTH +: BUS_WIDTH], then i increments. When word BURST_LEN-1 is accepted → WRITE, and `wr_addr` is latched as base_addr + wr_ptr*(BUS_WIDTH/8).
- WRITE: `wr_enable`=1.
  - Status 2 → RELEASE. `wr_ptr` += BURST_LEN, or wraps to 0 if the result ≥ buf_words.
  - Status 3 → ERROR. Set `err`; `wr_ptr` is unchanged.
- RELEASE: `wr_enable`=0. Wait for `wr_status`==0, then go to FILL with i=0, or to IDLE if `stop` is high.
- ERROR: `wr_enable`=0, `s_ready`=0. Only `start` (once `wr_status`==0) or `stop` leaves this state; `stop` → IDLE.
- `stop` in FILL: discard the partial burst → IDLE. `stop` in WRITE: the burst completes first; RELEASE then honours `stop`.
- `start` is ignored outside IDLE/ERROR.
- Constant outputs: `wr_burst_len`=BURST_LEN-1; `wr_burst_size`=log2(BUS_WIDTH/8); `wr_strb` all ones.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. `wr_ptr` compare uses CNT_WIDTH+1 bits to avoid overflow.

## Timing
- Reset values: state IDLE; `s_ready`, `wr_enable`, `busy`, `err` = 0; `wr_ptr`, `drop_count` = 0; `wr_addr`, `wr_data` = 0.
- Sample acceptance: one word per cycle, sustained in FILL.
- `wr_enable` rises on the cycle after the last sample is accepted.
- Status 2/3 is sampled registered. `wr_enable` falls on the next cycle, and `wr_ptr` updates on that same edge.
- `wr_addr` and `wr_data` are stable from `wr_enable` rise until RELEASE exits.
- Minimum burst-to-burst gap: 2 cycles (RELEASE sees status 0 one cycle after enable drops).
- Reset mid-burst returns all outputs to reset values immediately; `axi_wr` shares the same reset.

## Configuration
- Macro: `ADC_BURST_WR_DROP_EN`.
- Defined:
  - `s_ready`=1 in WRITE and RELEASE; samples accepted there are discarded and increment `drop_count` (saturating).
  - `start` clears `drop_count`.
  - The ADC never stalls.
- Undefined:
  - `s_ready`=0 outside FILL, applying backpressure.
  - `drop_count` is tied to 0.

## Structure
- Package `adc_f2h_pkg`:
  - state encoding;
  - `axi_wr` status constants (READY=0, WAIT=1, OK=2, ERR=3);
  - burst type INCR=2'b01.
- Sub-module `adc_burst_addr_gen`: holds `wr_ptr`, performs the wrap compare, and produces `wr_addr`. Its inputs are `base_addr`, `buf_words`, clear and advance.

## Test plan
- BURST_LEN=4, buf_words=8, base=0x1000, `axi_wr` model OKs → bursts at 0x1000, 0x1010, 0x1000; `wr_ptr` sequence 4, 0, 4.
- Samples 0xA0..0xA3 → `wr_data` = {A3,A2,A1,A0}, `wr_burst_len`=3, `wr_burst_size`=2, `wr_strb`=4'hF.
- Model returns status 3 → `err`=1, state ERROR, `wr_ptr` unchanged, `s_ready`=0; a `start` pulse recovers with `err`=0.
- `stop` after 2 of 4 samples → IDLE with no `wr_enable`. `stop` during WRITE → burst completes, then IDLE.
- Status held at 1 for 20 cycles with macro undefined → `s_ready`=0 throughout. With the macro defined, 20 offered samples → `drop_count`=20.
- Reset asserted while `wr_enable`=1 → all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/adc_f2h_pkg.sv
// adc_f2h_pkg: shared FSM state encoding and axi_wr status/burst constants
// for the ADC-to-HPS burst writer.
package adc_f2h_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_RELEASE,
        ST_ERROR
    } state_t;
    localparam logic [1:0] WR_READY = 2'd0;
    localparam logic [1:0] WR_WAIT = 2'd1;
    localparam logic [1:0] WR_OK = 2'd2;
    localparam logic [1:0] WR_ERR = 2'd3;
    localparam logic [1:0] BURST_INCR = 2'b01;
endpackage

// File: rtl/adc_burst_addr_gen.sv
// adc_burst_addr_gen: circular word pointer and latched byte address for the DDR window.
// Ports: clock, reset_n (async, active-low); i_base_addr window base; i_buf_words
// window size in words; i_clear zeroes the pointer; i_advance steps it by one
// burst with wrap; i_load captures the address of the current slot;
// o_wr_ptr word offset of the next slot; o_wr_addr latched byte address.
module adc_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH = 16,
    parameter int BUS_WIDTH = 32,
    parameter int BURST_LEN = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]  i_buf_words,
    input  logic                  i_clear,
    input  logic                  i_advance,
    input  logic                  i_load,
    output logic [CNT_WIDTH-1:0]  o_wr_ptr,
    output logic [ADDR_WIDTH-1:0] o_wr_addr
);
    logic [CNT_WIDTH-1:0]  r_ptr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH:0]    w_sum;
    logic [ADDR_WIDTH-1:0] w_addr;
    // One extra bit so ptr+BURST_LEN cannot overflow before the wrap compare.
    assign w_sum = {1'b0, r_ptr} + (CNT_WIDTH+1)'(BURST_LEN);
    assign w_addr = i_base_addr + (ADDR_WIDTH'(r_ptr) << $clog2(BUS_WIDTH/8));
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
            r_addr <= '0;
        end else begin
            if (i_clear)
                r_ptr <= '0;
            else if (i_advance)
                r_ptr <= (w_sum >= {1'b0, i_buf_words}) ? '0 : w_sum[CNT_WIDTH-1:0];
            if (i_load)
                r_addr <= w_addr;
        end
    end
    assign o_wr_ptr = r_ptr;
    assign o_wr_addr = r_addr;
endmodule

// File: rtl/adc_burst_writer.sv
// adc_burst_writer: assembles ADC samples into bursts and drives axi_wr into a circular DDR window.
// Ports: clock, reset_n (async, active-low); i_start/i_stop control; i_wr_id_in,
// i_base_addr, i_buf_words configuration; i_s_data/i_s_valid/o_s_ready sample
// stream; o_wr_* and i_wr_status to axi_wr; o_wr_ptr, o_busy, o_err,
// o_drop_count status. Macro ADC_BURST_WR_DROP_EN keeps s_ready high during
// WRITE/RELEASE and counts the discarded samples instead of backpressuring.
module adc_burst_writer
    import adc_f2h_pkg::*;
#(
    parameter int ID_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH = 32,
    parameter int BURST_LEN = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic [ID_WIDTH-1:0]            i_wr_id_in,
    input  logic [ADDR_WIDTH-1:0]          i_base_addr,
    input  logic [CNT_WIDTH-1:0]           i_buf_words,
    input  logic [BUS_WIDTH-1:0]           i_s_data,
    input  logic                           i_s_valid,
    output logic                           o_s_ready,
    output logic                           o_wr_enable,
    output logic [ID_WIDTH-1:0]            o_wr_id,
    output logic [ADDR_WIDTH-1:0]          o_wr_addr,
    output logic [BURST_LEN*BUS_WIDTH-1:0] o_wr_data,
    output logic [3:0]                     o_wr_burst_len,
    output logic [2:0]                     o_wr_burst_size,
    output logic [BUS_WIDTH/8-1:0]         o_wr_strb,
    input  logic [1:0]                     i_wr_status,
    output logic [CNT_WIDTH-1:0]           o_wr_ptr,
    output logic                           o_busy,
    output logic                           o_err,
    output logic [CNT_WIDTH-1:0]           o_drop_count
);
    localparam int IDX_W = $clog2(BURST_LEN) + 1;
    state_t                       r_state, w_next;
    logic [IDX_W-1:0]             r_idx;
    logic [BURST_LEN*BUS_WIDTH-1:0] r_data;
    logic                         r_err;
    logic                         w_accept, w_clear, w_advance, w_load, w_set_err;
    assign w_accept = (r_state == ST_FILL) && i_s_valid;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_clear = 1'b0;
        w_advance = 1'b0;
        w_load = 1'b0;
        w_set_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = ST_FILL;
                    w_clear = 1'b1;
                end
            end
            ST_FILL: begin
                // Stop wins over a simultaneous final sample: the partial burst is dropped.
                if (i_stop)
                    w_next = ST_IDLE;
                else if (w_accept && r_idx == IDX_W'(BURST_LEN-1)) begin
                    w_next = ST_WRITE;
                    w_load = 1'b1;
                end
            end
            ST_WRITE: begin
                if (i_wr_status == WR_OK) begin
                    w_next = ST_RELEASE;
                    w_advance = 1'b1;
                end else if (i_wr_status == WR_ERR) begin
                    w_next = ST_ERROR;
                    w_set_err = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (i_wr_status == WR_READY)
                    w_next = i_stop ? ST_IDLE : ST_FILL;
            end
            ST_ERROR: begin
                if (i_stop)
                    w_next = ST_IDLE;
                else if (i_start && i_wr_status == WR_READY) begin
                    w_next = ST_FILL;
                    w_clear = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
            r_data <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data[r_idx*BUS_WIDTH +: BUS_WIDTH] <= i_s_data;
                r_idx <= r_idx + 1'b1;
            end else if (r_state != ST_FILL)
                r_idx <= '0;
            if (w_clear)
                r_err <= 1'b0;
            else if (w_set_err)
                r_err <= 1'b1;
        end
    end
`ifdef ADC_BURST_WR_DROP_EN
    logic [CNT_WIDTH-1:0] r_drop;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_drop <= '0;
        else if (w_clear)
            r_drop <= '0;
        else if (i_s_valid && (r_state == ST_WRITE || r_state == ST_RELEASE) && r_drop != '1)
            r_drop <= r_drop + 1'b1;
    end
    assign o_s_ready = (r_state == ST_FILL) || (r_state == ST_WRITE) || (r_state == ST_RELEASE);
    assign o_drop_count = r_drop;
`else
    assign o_s_ready = (r_state == ST_FILL);
    assign o_drop_count = '0;
`endif
    adc_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH(CNT_WIDTH),
        .BUS_WIDTH(BUS_WIDTH),
        .BURST_LEN(BURST_LEN)
    ) u_addr (
        .clock(clock),
        .reset_n(reset_n),
        .i_base_addr(i_base_addr),
        .i_buf_words(i_buf_words),
        .i_clear(w_clear),
        .i_advance(w_advance),
        .i_load(w_load),
        .o_wr_ptr(o_wr_ptr),
        .o_wr_addr(o_wr_addr)
    );
    assign o_wr_enable = (r_state == ST_WRITE);
    assign o_wr_id = i_wr_id_in;
    assign o_wr_data = r_data;
    assign o_wr_burst_len = 4'(BURST_LEN-1);
    assign o_wr_burst_size = 3'($clog2(BUS_WIDTH/8));
    assign o_wr_strb = '1;
    assign o_busy = (r_state != ST_IDLE);
    assign o_err = r_err;
endmodule

// File: tb/tb_adc_burst_writer.sv
// tb_adc_burst_writer: directed bench for adc_burst_writer with BURST_LEN=4, 8-word window at 0x1000.
module tb_adc_burst_writer;
    logic         clock = 1'b0;
    logic         reset_n;
    logic         i_start, i_stop, i_s_valid;
    logic [7:0]   i_wr_id_in;
    logic [31:0]  i_base_addr, i_s_data;
    logic [15:0]  i_buf_words;
    logic [1:0]   i_wr_status;
    logic         o_s_ready, o_wr_enable, o_busy, o_err;
    logic [7:0]   o_wr_id;
    logic [31:0]  o_wr_addr;
    logic [127:0] o_wr_data;
    logic [3:0]   o_wr_burst_len, o_wr_strb;
    logic [2:0]   o_wr_burst_size;
    logic [15:0]  o_wr_ptr, o_drop_count;
    int n_tests = 0;
    int n_fail = 0;
    int n_ready;

    adc_burst_writer #(.ID_WIDTH(8), .ADDR_WIDTH(32), .BUS_WIDTH(32), .BURST_LEN(4), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .i_start(i_start), .i_stop(i_stop),
        .i_wr_id_in(i_wr_id_in), .i_base_addr(i_base_addr), .i_buf_words(i_buf_words),
        .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
        .o_wr_enable(o_wr_enable), .o_wr_id(o_wr_id), .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data), .o_wr_burst_len(o_wr_burst_len), .o_wr_burst_size(o_wr_burst_size),
        .o_wr_strb(o_wr_strb), .i_wr_status(i_wr_status), .o_wr_ptr(o_wr_ptr),
        .o_busy(o_busy), .o_err(o_err), .o_drop_count(o_drop_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic fill(input logic [31:0] first);
        for (int k = 0; k < 4; k++) begin
            i_s_data = first + 32'(k);
            i_s_valid = 1'b1;
            step();
        end
        i_s_valid = 1'b0;
    endtask

    task automatic complete(input string tag, input logic [31:0] addr, input logic [15:0] ptr);
        check({tag, "_en"}, 128'(o_wr_enable), 128'd1);
        check({tag, "_addr"}, 128'(o_wr_addr), 128'(addr));
        i_wr_status = 2'd1;
        step();
        check({tag, "_en_wait"}, 128'(o_wr_enable), 128'd1);
        i_wr_status = 2'd2;
        step();
        check({tag, "_en_fall"}, 128'(o_wr_enable), 128'd0);
        check({tag, "_ptr"}, 128'(o_wr_ptr), 128'(ptr));
        i_wr_status = 2'd0;
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        i_start = 1'b0;
        i_stop = 1'b0;
        i_s_valid = 1'b0;
        i_s_data = '0;
        i_wr_id_in = 8'h5A;
        i_base_addr = 32'h1000;
        i_buf_words = 16'd8;
        i_wr_status = 2'd0;
        step();
        step();
        check("rst_busy", 128'(o_busy), 128'd0);
        check("rst_ready", 128'(o_s_ready), 128'd0);
        check("rst_en", 128'(o_wr_enable), 128'd0);
        check("rst_err", 128'(o_err), 128'd0);
        check("rst_ptr", 128'(o_wr_ptr), 128'd0);
        check("rst_addr", 128'(o_wr_addr), 128'd0);
        check("rst_data", o_wr_data, 128'd0);
        check("rst_drop", 128'(o_drop_count), 128'd0);
        reset_n = 1'b1;
        step();
        check("const_len", 128'(o_wr_burst_len), 128'd3);
        check("const_size", 128'(o_wr_burst_size), 128'd2);
        check("const_strb", 128'(o_wr_strb), 128'hF);
        check("wr_id", 128'(o_wr_id), 128'h5A);
        check("idle_ready", 128'(o_s_ready), 128'd0);

        pulse_start();
        check("fill_ready", 128'(o_s_ready), 128'd1);
        check("fill_busy", 128'(o_busy), 128'd1);
        fill(32'hA0);
        check("b1_data", o_wr_data, 128'h000000A3_000000A2_000000A1_000000A0);
`ifndef ADC_BURST_WR_DROP_EN
        check("write_bp", 128'(o_s_ready), 128'd0);
`endif
        complete("b1", 32'h1000, 16'd4);
        check("b1_refill", 128'(o_s_ready), 128'd1);
        fill(32'hB0);
        check("b2_data", o_wr_data, 128'h000000B3_000000B2_000000B1_000000B0);
        complete("b2", 32'h1010, 16'd0);
        fill(32'hC0);
        complete("b3", 32'h1000, 16'd4);

        fill(32'hD0);
        check("b4_addr", 128'(o_wr_addr), 128'h1010);
        i_wr_status = 2'd3;
        step();
        check("err_flag", 128'(o_err), 128'd1);
        check("err_en", 128'(o_wr_enable), 128'd0);
        check("err_ready", 128'(o_s_ready), 128'd0);
        check("err_ptr", 128'(o_wr_ptr), 128'd4);
        check("err_busy", 128'(o_busy), 128'd1);
        pulse_start();
        check("err_hold", 128'(o_err), 128'd1);
        i_wr_status = 2'd0;
        pulse_start();
        check("recover_err", 128'(o_err), 128'd0);
        check("recover_ptr", 128'(o_wr_ptr), 128'd0);
        check("recover_ready", 128'(o_s_ready), 128'd1);

        i_s_valid = 1'b1;
        i_s_data = 32'hE0;
        step();
        i_s_data = 32'hE1;
        step();
        i_s_valid = 1'b0;
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        check("stopfill_busy", 128'(o_busy), 128'd0);
        check("stopfill_en", 128'(o_wr_enable), 128'd0);
        step();
        check("stopfill_en2", 128'(o_wr_enable), 128'd0);

        pulse_start();
        fill(32'hF0);
        i_stop = 1'b1;
        i_wr_status = 2'd1;
        step();
        check("stopwr_en", 128'(o_wr_enable), 128'd1);
        i_wr_status = 2'd2;
        step();
        check("stopwr_rel", 128'(o_wr_enable), 128'd0);
        check("stopwr_ptr", 128'(o_wr_ptr), 128'd4);
        check("stopwr_busy", 128'(o_busy), 128'd1);
        i_wr_status = 2'd0;
        step();
        i_stop = 1'b0;
        check("stopwr_idle", 128'(o_busy), 128'd0);

        pulse_start();
        fill(32'h10);
        i_wr_status = 2'd1;
        i_s_valid = 1'b1;
        n_ready = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_s_ready) n_ready++;
            step();
        end
        i_s_valid = 1'b0;
        check("wait_en", 128'(o_wr_enable), 128'd1);
`ifdef ADC_BURST_WR_DROP_EN
        check("wait_ready_cnt", 128'(n_ready), 128'd20);
        check("drop_count", 128'(o_drop_count), 128'd20);
`else
        check("wait_ready_cnt", 128'(n_ready), 128'd0);
        check("drop_count", 128'(o_drop_count), 128'd0);
`endif
        i_wr_status = 2'd2;
        step();
        i_wr_status = 2'd0;
        step();
        fill(32'h20);
        check("pre_rst_en", 128'(o_wr_enable), 128'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_en", 128'(o_wr_enable), 128'd0);
        check("arst_busy", 128'(o_busy), 128'd0);
        check("arst_ready", 128'(o_s_ready), 128'd0);
        check("arst_ptr", 128'(o_wr_ptr), 128'd0);
        check("arst_addr", 128'(o_wr_addr), 128'd0);
        check("arst_data", o_wr_data, 128'd0);
        check("arst_err", 128'(o_err), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
